// File: rtl/servo_pkg.sv
// Shared constants, width/channel types and the clamp helper
// for the servo frame timebase and ramp scheduler.
package servo_pkg;

  localparam int FRAME  = 20000;
  localparam int MIN_W  = 1000;
  localparam int MAX_W  = 2200;
  localparam int INIT_W = 1500;
  localparam int STEP   = 10;
  localparam int CHW    = 2;

  typedef logic [11:0]     width_t;
  typedef logic [CHW-1:0]  ch_t;
  typedef logic [14:0]     cnt_t;

  function automatic width_t clamp_w(
    input width_t w,
    input width_t lo,
    input width_t hi
  );
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

endpackage

// File: rtl/servo_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer
// favours the requester that was not served last.
module servo_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  logic prio_a;

  assign a_grant = a_valid & (~b_valid | prio_a);
  assign b_grant = b_valid & (~a_valid | ~prio_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_a <= 1'b1;
    end else if (a_grant | b_grant) begin
      prio_a <= b_grant;
    end
  end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Servo frame timebase, arbitrated target writes and
// per-channel slew-limited pulse width ramps.
module servo_ramp_scheduler #(
  parameter int NCH    = 4,
  parameter int CHW    = 2,
  parameter int FRAME  = servo_pkg::FRAME,
  parameter int MIN_W  = servo_pkg::MIN_W,
  parameter int MAX_W  = servo_pkg::MAX_W,
  parameter int INIT_W = servo_pkg::INIT_W,
  parameter int STEP   = servo_pkg::STEP
) (
  input  logic           mclk,
  input  logic           rst_n,
  input  logic           a_valid,
  input  logic [CHW-1:0] a_ch,
  input  logic [11:0]    a_width,
  output logic           a_ready,
  input  logic           b_valid,
  input  logic [CHW-1:0] b_ch,
  input  logic [11:0]    b_width,
  output logic           b_ready,
  input  logic           freeze,
  output logic [NCH-1:0] pwm,
  output logic           frame_start,
  output logic [NCH-1:0] at_target,
  output logic           clamped
);

  import servo_pkg::*;

  localparam cnt_t   LAST   = cnt_t'(FRAME - 1);
  localparam width_t LO     = width_t'(MIN_W);
  localparam width_t HI     = width_t'(MAX_W);
  localparam width_t INIT   = width_t'(INIT_W);
  localparam width_t STEP_W = width_t'(STEP);

  cnt_t           frame_cnt;
  logic           wrap;
  logic           wr;
  logic [CHW-1:0] wch;
  width_t         raw;
  width_t         wval;

  assign wrap        = frame_cnt == LAST;
  assign frame_start = frame_cnt == '0;

  servo_rr_arb2 u_arb (
    .clk     (mclk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_grant (a_ready),
    .b_grant (b_ready)
  );

  assign wr   = a_ready | b_ready;
  assign wch  = a_ready ? a_ch : b_ch;
  assign raw  = a_ready ? a_width : b_width;
  assign wval = clamp_w(raw, LO, HI);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      clamped   <= 1'b0;
    end else begin
      frame_cnt <= wrap ? '0 : frame_cnt + 15'd1;
      clamped   <= wr && (raw < LO || raw > HI);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    width_t      cur;
    width_t      tgt;
    width_t      mag;
    width_t      stp;
    width_t      nxt;
    logic [12:0] diff;
    logic        pwm_q;
    logic        at_q;

    // 13-bit difference keeps the direction bit out of the magnitude
    always_comb begin
      diff = {1'b0, tgt} - {1'b0, cur};
      mag  = diff[12] ? 12'(13'd0 - diff) : diff[11:0];
      stp  = (mag > STEP_W) ? STEP_W : mag;
      nxt  = diff[12] ? cur - stp : cur + stp;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
        cur   <= INIT;
        tgt   <= INIT;
        pwm_q <= 1'b0;
        at_q  <= 1'b1;
      end else begin
        if (wr && wch == CHW'(i)) tgt <= wval;
        if (wrap && !freeze) cur <= nxt;
        pwm_q <= frame_cnt < {3'b000, cur};
        at_q  <= cur == tgt;
      end
    end

    assign pwm[i]       = pwm_q;
    assign at_target[i] = at_q;
  end

endmodule
